// File: rtl/uart_pkg.sv
// Shared constants for the UART receiver.
//   - FSM state encoding (IDLE/START/DATA/STOP)
//   - default frame geometry (8 data bits, 1 stop bit = 16 ticks)
//   - oversampling constants (16x, mid start bit at tick 7)
package uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;

  localparam int START_MID  = 7;
  localparam int OVERSAMPLE = 16;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset; both flops load RST_VAL
//   d     - asynchronous input
//   q     - synchronized output (2 clk cycles of latency)
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_ff1;
  logic r_ff2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ff1 <= RST_VAL;
      r_ff2 <= RST_VAL;
    end else begin
      r_ff1 <= d;
      r_ff2 <= r_ff1;
    end
  end

  assign q = r_ff2;

endmodule

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling, DBIT data bits LSB first, and a stop
// period of SB_TICK ticks. Glitch starts (line high again at mid start bit)
// are dropped; a stop bit sampled low gives a framing-error pulse.
// Ports:
//   clk          - system clock
//   reset        - asynchronous active-low reset
//   s_tick       - one-clk pulse at 16x baud
//   rx           - raw serial line, idle high, asynchronous
//   dout         - last received word (updated on good and bad frames)
//   rx_done_tick - one-cycle pulse, frame ended with stop bit = 1
//   frame_err    - one-cycle pulse, frame ended with stop bit = 0
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  logic            w_rx_s;
  logic            r_rx_q;
  logic [1:0]      r_state;
  logic [4:0]      r_s;
  logic [NW-1:0]   r_n;
  logic [DBIT-1:0] r_b;
  logic [DBIT-1:0] r_dout;
  logic            r_done;
  logic            r_ferr;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (rx),
    .q     (w_rx_s)
  );

  // Previous synchronized sample, used for falling-edge start detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_rx_q <= 1'b1;
    else        r_rx_q <= w_rx_s;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ferr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Only a fresh falling edge starts a frame, so a held-low line
          // (break after a framing error) never retriggers.
          if (r_rx_q && !w_rx_s) begin
            r_state <= ST_START;
            r_s     <= '0;
          end
        end
        ST_START: begin
          if (s_tick) begin
            if (r_s == 5'(START_MID)) begin
              if (!w_rx_s) begin
                r_state <= ST_DATA;
                r_s     <= '0;
                r_n     <= '0;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_s <= r_s + 5'd1;
            end
          end
        end
        ST_DATA: begin
          if (s_tick) begin
            if (r_s == 5'(OVERSAMPLE - 1)) begin
              r_b <= {w_rx_s, r_b[DBIT-1:1]};
              r_s <= '0;
              if (r_n == NW'(DBIT - 1)) r_state <= ST_STOP;
              else                      r_n     <= r_n + NW'(1);
            end else begin
              r_s <= r_s + 5'd1;
            end
          end
        end
        default: begin  // ST_STOP
          if (s_tick) begin
            if (r_s == 5'(SB_TICK - 1)) begin
              r_dout  <= r_b;
              r_done  <= w_rx_s;
              r_ferr  <= ~w_rx_s;
              r_state <= ST_IDLE;
            end else begin
              r_s <= r_s + 5'd1;
            end
          end
        end
      endcase
    end
  end

  assign dout         = r_dout;
  assign rx_done_tick = r_done;
  assign frame_err    = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BITCLK = 64;  // s_tick every 4 clk, 16 ticks per bit

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_tick = 1'b0;
  logic       rx8 = 1'b1;
  logic       rx7 = 1'b1;
  logic [7:0] dout8;
  logic [6:0] dout7;
  logic       done8, ferr8, done7, ferr7;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut8 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx8),
    .dout(dout8), .rx_done_tick(done8), .frame_err(ferr8)
  );

  uart_rx #(.DBIT(7), .SB_TICK(32)) dut7 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx7),
    .dout(dout7), .rx_done_tick(done7), .frame_err(ferr7)
  );

  always #5 clk = ~clk;

  // Observed output events: kind 1 = rx_done_tick, 0 = frame_err.
  typedef struct {
    logic       done;
    logic [7:0] d;
    int         t;
  } ev_t;

  ev_t q8[$];
  ev_t q7[$];
  ev_t exp_q[$];
  int  tcnt = 0;
  int  both_hi = 0;
  int  n_chk = 0;
  int  n_pass = 0;
  int  t_start8 = 0;
  int  t_start7 = 0;

  // Tick generator and output monitor, both on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      tcnt++;
      s_tick = (tcnt % 4 == 0);
      if (done8 && ferr8) both_hi++;
      if (done7 && ferr7) both_hi++;
      if (done8 || ferr8) q8.push_back('{done8, dout8, tcnt});
      if (done7 || ferr7) q7.push_back('{done7, {1'b0, dout7}, tcnt});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_bits(input int nb);
    repeat (nb * BITCLK) @(negedge clk);
  endtask

  task automatic send8(input logic [7:0] d, input logic stopv);
    rx8 = 1'b0;
    t_start8 = tcnt;
    wait_bits(1);
    for (int i = 0; i < 8; i++) begin
      rx8 = d[i];
      wait_bits(1);
    end
    rx8 = stopv;
    wait_bits(1);
  endtask

  task automatic send7(input logic [6:0] d);
    rx7 = 1'b0;
    t_start7 = tcnt;
    wait_bits(1);
    for (int i = 0; i < 7; i++) begin
      rx7 = d[i];
      wait_bits(1);
    end
    rx7 = 1'b1;
    wait_bits(2);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stopv;
    logic       exp_done;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [7:0] rd;
    logic       rs;
    logic       prev_bad;
    int         gap;
    int         dt;

    tbl[0] = '{8'h55, 1'b1, 1'b1, 8'h55};
    tbl[1] = '{8'h00, 1'b1, 1'b1, 8'h00};
    tbl[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF};
    tbl[3] = '{8'h81, 1'b1, 1'b1, 8'h81};
    tbl[4] = '{8'h6E, 1'b0, 1'b0, 8'h6E};
    tbl[5] = '{8'hB2, 1'b1, 1'b1, 8'hB2};

    // Reset state
    repeat (5) @(negedge clk);
    chk("rst_dout", 32'(dout8), 32'h0);
    chk("rst_done", 32'(done8), 32'h0);
    chk("rst_ferr", 32'(ferr8), 32'h0);
    reset = 1'b1;
    wait_bits(1);
    chk("idle_no_event", 32'(q8.size()), 32'd0);

    // Table-driven single frames with an idle gap after each
    foreach (tbl[k]) begin
      q8.delete();
      send8(tbl[k].data, tbl[k].stopv);
      rx8 = 1'b1;
      wait_bits(2);
      chk($sformatf("tbl%0d_count", k), 32'(q8.size()), 32'd1);
      if (q8.size() >= 1) begin
        chk($sformatf("tbl%0d_kind", k), 32'(q8[0].done), 32'(tbl[k].exp_done));
        chk($sformatf("tbl%0d_dout", k), 32'(q8[0].d), 32'(tbl[k].exp_dout));
        if (k == 0) begin
          // 8N1 frame ends 152 ticks (608 clk) after the start edge,
          // plus synchronizer/tick-phase slack.
          dt = q8[0].t - t_start8;
          chk("frame_time_8n1", 32'(dt >= 151 * 4 && dt <= 154 * 4), 32'd1);
        end
      end
    end

    // Back-to-back frames, no idle gap
    q8.delete();
    send8(8'hA3, 1'b1);
    send8(8'h0F, 1'b1);
    wait_bits(2);
    chk("b2b_count", 32'(q8.size()), 32'd2);
    if (q8.size() == 2) begin
      chk("b2b_d0", 32'(q8[0].d), 32'hA3);
      chk("b2b_d1", 32'(q8[1].d), 32'h0F);
      chk("b2b_kind", 32'({q8[0].done, q8[1].done}), 32'd3);
    end

    // 3-tick glitch on an idle line
    q8.delete();
    rx8 = 1'b0;
    repeat (12) @(negedge clk);
    rx8 = 1'b1;
    repeat (28) @(negedge clk);
    repeat (8) @(negedge clk);
    chk("glitch_idle", 32'(dut8.r_state), 32'(ST_IDLE));
    wait_bits(2);
    chk("glitch_no_event", 32'(q8.size()), 32'd0);

    // Framing error followed by a held-low break
    q8.delete();
    send8(8'hC4, 1'b0);
    wait_bits(4);
    chk("ferr_count", 32'(q8.size()), 32'd1);
    if (q8.size() >= 1) begin
      chk("ferr_kind", 32'(q8[0].done), 32'd0);
      chk("ferr_dout", 32'(q8[0].d), 32'hC4);
    end
    chk("ferr_dout_hold", 32'(dout8), 32'hC4);
    rx8 = 1'b1;
    wait_bits(2);

    // Reset in the middle of DATA bit 4 of 0xFF
    q8.delete();
    rx8 = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 4; i++) begin
      rx8 = 1'b1;
      wait_bits(1);
    end
    repeat (BITCLK / 2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_dout", 32'(dout8), 32'h0);
    chk("midrst_done", 32'(done8), 32'h0);
    chk("midrst_ferr", 32'(ferr8), 32'h0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    wait_bits(8);
    chk("midrst_no_event", 32'(q8.size()), 32'd0);
    send8(8'h3C, 1'b1);
    wait_bits(2);
    chk("post_rst_count", 32'(q8.size()), 32'd1);
    if (q8.size() >= 1) begin
      chk("post_rst_kind", 32'(q8[0].done), 32'd1);
      chk("post_rst_dout", 32'(q8[0].d), 32'h3C);
    end

    // Random frames against a frame-level reference: each frame yields one
    // event carrying its data; the event kind is the stop-bit value.
    q8.delete();
    exp_q.delete();
    prev_bad = 1'b0;
    for (int f = 0; f < 20; f++) begin
      rd = 8'($urandom);
      rs = ($urandom_range(0, 4) != 0);
      // A new start needs a rising then falling edge after a low stop bit.
      gap = prev_bad ? $urandom_range(1, 2) : $urandom_range(0, 2);
      rx8 = 1'b1;
      wait_bits(gap);
      send8(rd, rs);
      exp_q.push_back('{rs, rd, 0});
      prev_bad = ~rs;
    end
    rx8 = 1'b1;
    wait_bits(2);
    chk("rand_count", 32'(q8.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < q8.size(); i++) begin
      chk($sformatf("rand%0d_dout", i), 32'(q8[i].d), 32'(exp_q[i].d));
      chk($sformatf("rand%0d_kind", i), 32'(q8[i].done), 32'(exp_q[i].done));
    end

    // DBIT=7, two stop bits
    q7.delete();
    send7(7'h5A);
    chk("d7_count", 32'(q7.size()), 32'd1);
    if (q7.size() >= 1) begin
      chk("d7_kind", 32'(q7[0].done), 32'd1);
      chk("d7_dout", 32'(q7[0].d), 32'h5A);
      dt = q7[0].t - t_start7;
      chk("d7_frame_time", 32'(dt >= 151 * 4 && dt <= 154 * 4), 32'd1);
    end

    chk("never_both_pulses", 32'(both_hi), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, 8N1 by default, that recovers bytes from the `rx` line using the 16x oversampling pulse from the baud rate generator. It sits directly downstream of the baud rate generator. It delivers each received word with a one-cycle strobe to the consumer (FIFO/interface logic). It detects glitch starts and framing errors.

## Interface
- `DBIT`, 8: data bits per frame, LSB first; legal values 5–8.
- `SB_TICK`, 16: stop-bit duration in ticks (16 = 1 stop bit, 32 = 2); legal values 16–32.
- `clk` input 1: system clock; all state is on the rising edge.
- `reset` input 1: asynchronous, active-low; asserting it (0) clears all state immediately.
- `s_tick` input 1: one-`clk` pulse at 16x baud, from the baud rate generator.
- `rx` input 1: raw serial line; idle high; asynchronous to `clk`.
- `dout` output DBIT: last received word.
- `rx_done_tick` output 1: one-cycle pulse; `dout` is valid and the stop bit was 1.
- `frame_err` output 1: one-cycle pulse; the stop bit was sampled 0.

## Operation
- `rx` passes through a 2-flop synchronizer, giving `rx_s`. A third flop holds `rx_q`, the previous value of `rx_s`.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on a falling edge of `rx_s` (`rx_q`=1, `rx_s`=0). The tick counter `s` is set to 0.
  - START: on each `s_tick`, `s` increments. When `s_tick` arrives with `s`=7 (mid start bit):
    - If `rx_s`=0: go to DATA with `s`=0 and bit counter `n`=0.
    - If `rx_s`=1: treat it as a glitch and return to IDLE with no output.
  - DATA: on each `s_tick`, `s` increments. When `s_tick` arrives with `s`=15:
    - Shift `rx_s` into the MSB of the shift register `b` (right shift), then set `s`=0.
    - If `n`=DBIT-1, go to STOP; otherwise increment `n`.
  - STOP: on each `s_tick`, `s` increments. When `s_tick` arrives with `s`=SB_TICK-1:
    - Load `dout` ← `b`.
    - If `rx_s`=1, pulse `rx_done_tick`; otherwise pulse `frame_err`.
    - Go to IDLE in either case.
- A frame with a framing error still updates `dout`.
- A line held low after a framing error (break) does not retrigger: a new start requires a fresh falling edge.
- While `s_tick`=0, the counters and `b` hold their values.
- Width rules: `s` is 5 bits and `n` is $clog2(DBIT) bits. All counter compares are equality, so there is no wrap-around use.

## Timing
- Reset values: `dout`=0, `rx_done_tick`=0, `frame_err`=0, state=IDLE, `s`=0, `n`=0, `b`=0. Synchronizer flops and `rx_q` reset to 1 (idle line).
- Input latency: 2 `clk` cycles from `rx` to `rx_s`.
- Output timing: `rx_done_tick` / `frame_err` are registered outputs. They are high for exactly the one cycle after the `clk` edge that samples the final stop `s_tick`. `dout` changes on that same edge.
- Nominal frame time: start detection plus (8 + 16·DBIT + SB_TICK) ticks. For 8N1 that is 152 ticks.
- The consumer must capture `dout` before the next frame end. There is no backpressure; a new frame overwrites `dout`.
- Reset mid-frame: outputs clear immediately and the FSM returns to IDLE. A partially received frame is discarded with no pulse.
- Falling edge coincident with the end of STOP: it is ignored in that cycle, and detection resumes in IDLE on the next edge.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3).
  - Default `DBIT`/`SB_TICK` constants.
  - `START_MID`=7 and `OVERSAMPLE`=16 constants.
- One sub-module: `sync_2ff`, a 2-flop synchronizer with a reset value parameter and an async active-low reset. The rest is a single FSM with datapath.

## Test plan
The bench drives `s_tick` every 4 `clk` cycles; a bit lasts 64 cycles.

- Reset, then send 0x55 as 8N1:
  - `rx_done_tick` pulses once, for one cycle.
  - `dout`=0x55.
  - `frame_err` stays 0.
- Back-to-back frames 0xA3 then 0x0F with no idle gap:
  - Two `rx_done_tick` pulses.
  - `dout` reads 0xA3, then 0x0F.
- Drive a 3-tick low glitch on an idle line: no pulse on either output, and the FSM is back in IDLE by tick 8.
- Send 0xC4 with the stop bit forced to 0:
  - `frame_err` pulses once and `rx_done_tick` stays 0.
  - `dout`=0xC4.
  - Holding the line low afterwards produces no further frames.
- Assert `reset`=0 during DATA bit 4 of frame 0xFF, then release:
  - Outputs are 0 immediately.
  - The next clean frame 0x3C is received correctly.
- Set `DBIT`=7 and `SB_TICK`=32, then send 0x5A: `rx_done_tick` pulses, `dout`=0x5A, and the frame time is 8+112+32 ticks.
